alu_multicycle: RTL

Registered, parametrised successor to the combinational CPU ALU. It accepts one operation per start pulse and latches the operands, executes single-cycle ops in one clock, and runs MUL as a WIDTH-cycle shift-add iteration producing a 2*WIDTH product on aluout2:aluout1. It sits between register-file read and write-back, with a start/busy/done handshake to the control unit, and owns status-flag generation.

---
 rtl/alu_multicycle.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - registered ALU with single-cycle ops and a WIDTH-cycle shift-add MUL
module alu_multicycle #(
  parameter int WIDTH = 16,
  parameter int KW    = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [5:0]         encoded_opcode,
  input  logic [KW-1:0]      kbit,
  input  logic [WIDTH-1:0]   rs1data,
  input  logic [WIDTH-1:0]   rs2data,
  input  logic [7:0]         statusregin,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   aluout1,
  output logic [WIDTH-1:0]   aluout2,
  output logic [7:0]         statusregout
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  localparam logic [5:0] OP_INV = 6'b000110, OP_TWC = 6'b000111, OP_INC = 6'b001000,
                         OP_DEC = 6'b001001, OP_SEB = 6'b001101, OP_CLB = 6'b001110,
                         OP_ADD = 6'b010001, OP_ADC = 6'b010010, OP_SUB = 6'b010011,
                         OP_SBC = 6'b010100, OP_GHA = 6'b010101, OP_GHS = 6'b010110,
                         OP_AND = 6'b011101, OP_OR  = 6'b011110, OP_XOR = 6'b011111,
                         OP_MUL = 6'b100001, OP_FS_LO = 6'b101001, OP_FS_HI = 6'b110110;
  localparam logic [KW-1:0] LAST = KW'(WIDTH - 1);

  state_t              state;
  logic [KW-1:0]       cnt;
  logic [2*WIDTH-1:0]  acc, mcand, acc_next;
  logic [WIDTH-1:0]    mplier;
  logic [7:0]          sr_q, mul_sr;

  logic [WIDTH-1:0]    ax, ay, res;
  logic                acin, asub, ov, arith_f, logic_f;
  logic [WIDTH:0]      t;
  logic [7:0]          sr_n;
  logic [3:0]          fidx;

  // Shared adder/subtractor; t[WIDTH] is carry for adds and borrow for subtracts.
  always_comb begin
    ax   = rs1data;
    ay   = rs2data;
    acin = 1'b0;
    asub = 1'b0;
    case (encoded_opcode)
      OP_TWC: begin ax = '0; ay = rs1data; asub = 1'b1; end
      OP_INC: ay = {{(WIDTH-1){1'b0}}, 1'b1};
      OP_DEC: begin ay = {{(WIDTH-1){1'b0}}, 1'b1}; asub = 1'b1; end
      OP_ADC: acin = statusregin[2];
      OP_SUB, OP_GHS: asub = 1'b1;
      OP_SBC: begin asub = 1'b1; acin = statusregin[2]; end
      default: ;
    endcase
    if (asub) begin
      t  = {1'b0, ax} - {1'b0, ay} - {{WIDTH{1'b0}}, acin};
      ov = (ax[WIDTH-1] != ay[WIDTH-1]) && (t[WIDTH-1] != ax[WIDTH-1]);
    end else begin
      t  = {1'b0, ax} + {1'b0, ay} + {{WIDTH{1'b0}}, acin};
      ov = (ax[WIDTH-1] == ay[WIDTH-1]) && (t[WIDTH-1] != ax[WIDTH-1]);
    end
  end

  always_comb begin
    res     = rs1data;
    sr_n    = statusregin;
    arith_f = 1'b0;
    logic_f = 1'b0;
    fidx    = encoded_opcode[3:0] - 4'd9;
    case (encoded_opcode)
      OP_ADD, OP_ADC, OP_INC, OP_SUB, OP_SBC, OP_DEC, OP_TWC: begin
        res = t[WIDTH-1:0]; arith_f = 1'b1;
      end
      OP_GHA, OP_GHS: res = t[WIDTH-1:0];
      OP_INV: begin res = ~rs1data; logic_f = 1'b1; end
      OP_AND: begin res = rs1data & rs2data; logic_f = 1'b1; end
      OP_OR:  begin res = rs1data | rs2data; logic_f = 1'b1; end
      OP_XOR: begin res = rs1data ^ rs2data; logic_f = 1'b1; end
      OP_SEB: begin res[kbit] = 1'b1; logic_f = 1'b1; end
      OP_CLB: begin res[kbit] = 1'b0; logic_f = 1'b1; end
      default: begin
        // Set/clear pairs: even offset sets, odd offset clears, bit = offset/2.
        if (encoded_opcode >= OP_FS_LO && encoded_opcode <= OP_FS_HI)
          sr_n[fidx[3:1]] = ~fidx[0];
      end
    endcase
    if (arith_f || logic_f) begin
      sr_n[0] = (res == '0);
      sr_n[1] = res[WIDTH-1];
      sr_n[2] = arith_f & t[WIDTH];
      sr_n[4] = arith_f & ov;
    end
    sr_n[7] = 1'b0;
  end

  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    mul_sr    = sr_q;
    mul_sr[0] = (acc_next == '0);
    mul_sr[1] = acc_next[2*WIDTH-1];
    mul_sr[2] = 1'b0;
    mul_sr[4] = (acc_next[2*WIDTH-1:WIDTH] != '0);
    mul_sr[7] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      aluout1      <= '0;
      aluout2      <= '0;
      statusregout <= '0;
      cnt          <= '0;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      sr_q         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state        <= DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            aluout1      <= acc_next[WIDTH-1:0];
            aluout2      <= acc_next[2*WIDTH-1:WIDTH];
            statusregout <= mul_sr;
          end
        end
        default: begin
          if (start && encoded_opcode == OP_MUL) begin
            state  <= MUL;
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, rs1data};
            mplier <= rs2data;
            sr_q   <= statusregin;
          end else if (start) begin
            state        <= DONE;
            done         <= 1'b1;
            aluout1      <= res;
            aluout2      <= '0;
            statusregout <= sr_n;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
